// File: rtl/imem_boot_loader_if.sv
// Program-stream, instruction-memory and core-control bundle between a boot host and imem_boot_loader.
// The host drives start/len/s_valid/s_data/pc_in; the loader drives everything else.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic                  s_valid;
  logic [31:0]           s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_reset;
  logic [31:0]           pc_in;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [31:0]           cycle_count;

  modport master (
    output start, len, s_valid, s_data, pc_in,
    input  s_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, len, s_valid, s_data, pc_in,
    output s_ready, imem_we, imem_addr, imem_wdata, core_reset,
           busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory with the core held in reset, then releases the core
// and ends the run on a pc self-loop (halt) or a cycle limit (timeout).
module imem_boot_loader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STALL_CYCLES = 4,
  parameter int MAX_CYCLES   = 4096
) (
  input  logic               clk,
  input  logic               reset,
  imem_boot_loader_if.slave  bus
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic [31:0]           prev_pc_q, prev_pc_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic                  released_q, released_d;

  logic                  start_ok;
  logic [LW-1:0]         len_clamped;
  logic                  beat;
  logic                  last_beat;
  logic                  running;
  logic [31:0]           stall_next;
  logic [31:0]           cycle_next;
  logic                  halt_hit;
  logic                  limit_hit;

  // Shared decode; the halt/limit tests use the post-increment values so the run
  // ends on the very edge where the count reaches its threshold.
  always_comb begin
    start_ok    = bus.start && (bus.len != '0);
    len_clamped = (bus.len > DEPTH) ? DEPTH : bus.len;
    beat        = bus.s_valid && (state_q == LOAD);
    last_beat   = beat && (idx_q == len_q - LW'(1));
    running     = (state_q == RUN) && !core_reset_q;
    stall_next  = (released_q && (bus.pc_in == prev_pc_q)) ? stall_cnt_q + 32'd1 : 32'd0;
    cycle_next  = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
    halt_hit    = running && (stall_next == 32'(STALL_CYCLES));
    limit_hit   = running && (cycle_next == 32'(MAX_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      prev_pc_q     <= '0;
      stall_cnt_q   <= '0;
      released_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_reset_q  <= core_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      prev_pc_q     <= prev_pc_d;
      stall_cnt_q   <= stall_cnt_d;
      released_q    <= released_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    if (last_beat) state_d = RUN;
      RUN:     if (halt_hit || limit_hit) state_d = HALT;
      HALT:    if (start_ok) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d         = len_q;
    idx_d         = idx_q;
    imem_we_d     = beat;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    prev_pc_d     = prev_pc_q;
    stall_cnt_d   = stall_cnt_q;
    released_d    = released_q;
    done_d        = 1'b0;
    busy_d        = (state_d == LOAD) || (state_d == RUN);
    core_reset_d  = !((state_q == RUN) && (state_d == RUN));

    if (((state_q == IDLE) || (state_q == HALT)) && start_ok) begin
      len_d         = len_clamped;
      idx_d         = '0;
      cycle_count_d = '0;
      timeout_d     = 1'b0;
      stall_cnt_d   = '0;
      released_d    = 1'b0;
    end

    if (beat) begin
      imem_addr_d  = idx_q[ADDR_WIDTH-1:0];
      imem_wdata_d = bus.s_data;
      idx_d        = idx_q + LW'(1);
    end

    // The first released cycle has no valid prev_pc, so it only arms the stall detector.
    if (running) begin
      cycle_count_d = cycle_next;
      prev_pc_d     = bus.pc_in;
      stall_cnt_d   = stall_next;
      released_d    = 1'b1;
    end

    if ((state_q == RUN) && (state_d == HALT)) begin
      done_d    = 1'b1;
      timeout_d = !halt_hit;
    end
  end

  always_comb begin
    bus.s_ready     = (state_q == LOAD);
    bus.imem_we     = imem_we_q;
    bus.imem_addr   = imem_addr_q;
    bus.imem_wdata  = imem_wdata_q;
    bus.core_reset  = core_reset_q;
    bus.busy        = busy_q;
    bus.done        = done_q;
    bus.timeout     = timeout_q;
    bus.cycle_count = cycle_count_q;
  end

endmodule
